// File: rtl/candy_mem_arb_pkg.sv
// Shared types for the candy SRAM arbiter: state encoding, port ids and
// the latency-counter width helper.
package candy_mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_e;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    function automatic int cnt_width(input int read_lat);
        return (read_lat < 1) ? 1 : $clog2(read_lat + 1);
    endfunction

endpackage

// File: rtl/candy_mem_arb_if.sv
// Request/response bundle for the IF (read-only) and LS (read/write) ports.
// The master side issues requests; the slave side (the arbiter) acks them.
interface candy_mem_arb_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_ack;
    logic [DATA_W-1:0] ls_rdata;

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_wdata,
        input  if_ack, if_rdata,
        input  ls_ack, ls_rdata
    );

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        output if_ack, if_rdata,
        output ls_ack, ls_rdata
    );
endinterface

// File: rtl/candy_mem_arb_rr_pick2.sv
// Combinational two-way round-robin pick: on a tie the port that was not
// granted last time wins.
module candy_rr_pick2
    import candy_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_e      last,
    output port_e      gnt,
    output logic       valid
);
    always_comb begin
        valid = |req;
        gnt   = PORT_IF;
        if (req == 2'b11) begin
            gnt = (last == PORT_IF) ? PORT_LS : PORT_IF;
        end else if (req[1]) begin
            gnt = PORT_LS;
        end
    end
endmodule

// File: rtl/candy_mem_arb.sv
// Single-port SRAM sequencer shared by instruction fetch and load/store.
// One access in flight at a time; read data returns with a one-cycle ack.
module candy_mem_arb
    import candy_mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    candy_mem_arb_if.slave    bus,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy
);
    localparam int              CNT_W    = cnt_width(READ_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

    arb_state_e       state;
    port_e            last_gnt;
    port_e            gnt_port;
    logic             gnt_we;
    logic [CNT_W-1:0] cnt;

    logic [1:0] eligible;
    port_e      pick;
    logic       pick_valid;

    // A port acked this cycle is masked so a still-high req is not re-granted.
    assign eligible = {bus.ls_req & ~bus.ls_ack, bus.if_req & ~bus.if_ack};

    candy_rr_pick2 u_pick (
        .req   (eligible),
        .last  (last_gnt),
        .gnt   (pick),
        .valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            last_gnt    <= PORT_LS;
            gnt_port    <= PORT_IF;
            gnt_we      <= 1'b0;
            cnt         <= '0;
            sram_en     <= 1'b0;
            sram_we     <= 1'b0;
            sram_addr   <= '0;
            sram_wdata  <= '0;
            busy        <= 1'b0;
            bus.if_ack   <= 1'b0;
            bus.if_rdata <= '0;
            bus.ls_ack   <= 1'b0;
            bus.ls_rdata <= '0;
        end else begin
            // NOTE: strobes and acks default low here so each is a single-cycle pulse.
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            bus.if_ack <= 1'b0;
            bus.ls_ack <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        gnt_port <= pick;
                        last_gnt <= pick;
                        state    <= ARB_ISSUE;
                        busy     <= 1'b1;
                        sram_en  <= 1'b1;
                        if (pick == PORT_LS) begin
                            gnt_we     <= bus.ls_we;
                            sram_we    <= bus.ls_we;
                            sram_addr  <= bus.ls_addr;
                            sram_wdata <= bus.ls_wdata;
                        end else begin
                            gnt_we    <= 1'b0;
                            sram_addr <= bus.if_addr;
                        end
                    end
                end
                ARB_ISSUE: begin
                    if (gnt_we) begin
                        state <= ARB_IDLE;
                        busy  <= 1'b0;
                        if (gnt_port == PORT_LS) bus.ls_ack <= 1'b1;
                        else                     bus.if_ack <= 1'b1;
                    end else begin
                        cnt   <= CNT_LOAD;
                        state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= ARB_IDLE;
                        busy  <= 1'b0;
                        if (gnt_port == PORT_LS) begin
                            bus.ls_rdata <= sram_rdata;
                            bus.ls_ack   <= 1'b1;
                        end else begin
                            bus.if_rdata <= sram_rdata;
                            bus.if_ack   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_candy_mem_arb.sv
// Bench for candy_mem_arb: cycle-exact directed cases plus randomized traffic
// checked by a queue scoreboard against a memory-level reference model.
module tb_candy_mem_arb;
    import candy_mem_arb_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // READ_LAT = 1 instance
    candy_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dif ();
    logic              sram_en, sram_we, busy;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata, sram_rdata;

    candy_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(1)) dut (
        .clk(clk), .rst(rst), .bus(dif),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
    );

    // READ_LAT = 3 instance
    candy_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dif3 ();
    logic              s3_en, s3_we, busy3;
    logic [ADDR_W-1:0] s3_addr;
    logic [DATA_W-1:0] s3_wdata, s3_rdata;

    candy_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .bus(dif3),
        .sram_en(s3_en), .sram_we(s3_we), .sram_addr(s3_addr),
        .sram_wdata(s3_wdata), .sram_rdata(s3_rdata), .busy(busy3)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] init_val(input int a);
        if (a == 16) return 32'hDEAD_BEEF;
        return (DATA_W'(a) * 32'h9E37_79B1) ^ 32'h5A5A_3C3C;
    endfunction

    // SRAM model for the READ_LAT=1 instance; data is only valid in the one read cycle.
    logic [DATA_W-1:0] mem [0:63];
    bit   [63:0]       written;
    always @(posedge clk) begin
        sram_rdata <= 32'hBAD0_BAD0;
        if (sram_en) begin
            if (sram_we) begin
                mem[sram_addr[5:0]]     <= sram_wdata;
                written[sram_addr[5:0]] <= 1'b1;
            end else begin
                sram_rdata <= written[sram_addr[5:0]] ? mem[sram_addr[5:0]]
                                                      : init_val(int'(sram_addr[5:0]));
            end
        end
    end

    // Three-stage read pipe for the READ_LAT=3 instance.
    logic [2:0]        v3;
    logic [DATA_W-1:0] d3 [0:2];
    always @(posedge clk) begin
        if (rst) v3 <= '0;
        else     v3 <= {v3[1:0], s3_en & ~s3_we};
        d3[0] <= 32'hCAFE_0000 | DATA_W'(s3_addr);
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end
    assign s3_rdata = v3[2] ? d3[2] : 32'hBAD0_BAD0;

    // Reference model: IF reads addresses 0..31 (never written), LS owns 32..63.
    typedef struct {
        bit                wr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic [DATA_W-1:0] ref_mem [0:63];
    exp_t              if_q[$];
    exp_t              ls_q[$];
    logic [DATA_W-1:0] if_model = '0;
    logic [DATA_W-1:0] ls_model = '0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sram_we) check("we_with_en", 64'(sram_en), 64'd1);
        if (dif.if_ack || dif.ls_ack) check("ack_overlap", 64'(dif.if_ack & dif.ls_ack), 64'd0);
        if (dif.if_ack) begin
            check("if_ack_pending", 64'(if_q.size() != 0), 64'd1);
            if (if_q.size() != 0) begin
                e = if_q.pop_front();
                check("if_rdata", 64'(dif.if_rdata), 64'(e.data));
                if_model = e.data;
            end
            check("ls_rdata_hold", 64'(dif.ls_rdata), 64'(ls_model));
        end
        if (dif.ls_ack) begin
            check("ls_ack_pending", 64'(ls_q.size() != 0), 64'd1);
            if (ls_q.size() != 0) begin
                e = ls_q.pop_front();
                if (e.wr) begin
                    check("ls_rdata_on_write", 64'(dif.ls_rdata), 64'(ls_model));
                end else begin
                    check("ls_rdata", 64'(dif.ls_rdata), 64'(e.data));
                    ls_model = e.data;
                end
            end
            check("if_rdata_hold", 64'(dif.if_rdata), 64'(if_model));
        end
    end

    task automatic if_issue(input logic [ADDR_W-1:0] a);
        exp_t e;
        e.wr   = 1'b0;
        e.data = ref_mem[a[5:0]];
        if_q.push_back(e);
        dif.if_addr = a;
        dif.if_req  = 1'b1;
    endtask

    task automatic ls_issue(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_t e;
        e.wr   = we;
        e.data = we ? d : ref_mem[a[5:0]];
        if (we) ref_mem[a[5:0]] = d;
        ls_q.push_back(e);
        dif.ls_we    = we;
        dif.ls_addr  = a;
        dif.ls_wdata = d;
        dif.ls_req   = 1'b1;
    endtask

    task automatic if_wait_ack();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            seen = dif.if_ack;
        end
        check("if_ack_timeout", 64'(seen), 64'd1);
        if (!seen) dif.if_req = 1'b0;
    endtask

    task automatic ls_wait_ack();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            seen = dif.ls_ack;
        end
        check("ls_ack_timeout", 64'(seen), 64'd1);
        if (!seen) dif.ls_req = 1'b0;
    endtask

    // A zero gap keeps req high across the ack, exercising the mask cycle.
    task automatic if_random(input int n_txn);
        int gap;
        for (int n = 0; n < n_txn; n++) begin
            gap = int'($urandom_range(0, 3));
            if (gap != 0) begin
                dif.if_req = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            if_issue(ADDR_W'($urandom_range(0, 31)));
            if_wait_ack();
        end
        dif.if_req = 1'b0;
    endtask

    task automatic ls_random(input int n_txn);
        int gap;
        for (int n = 0; n < n_txn; n++) begin
            gap = int'($urandom_range(0, 3));
            if (gap != 0) begin
                dif.ls_req = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            ls_issue(bit'($urandom_range(0, 1)), ADDR_W'($urandom_range(32, 63)), DATA_W'($urandom));
            ls_wait_ack();
        end
        dif.ls_req = 1'b0;
    endtask

    // Per-cycle history, bit k = cycle k after the request became visible.
    logic [15:0]       h_en, h_we, h_ifack, h_lsack, h_busy;
    logic [ADDR_W-1:0] seen_addr;
    logic [DATA_W-1:0] seen_wdata;

    task automatic sample(input int n, input int if_drop, input int ls_drop);
        int if_n = 0;
        int ls_n = 0;
        h_en = '0; h_we = '0; h_ifack = '0; h_lsack = '0; h_busy = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            h_en[k]    = sram_en;
            h_we[k]    = sram_we;
            h_ifack[k] = dif.if_ack;
            h_lsack[k] = dif.ls_ack;
            h_busy[k]  = busy;
            if (sram_en) begin
                seen_addr  = sram_addr;
                seen_wdata = sram_wdata;
            end
            if (dif.if_ack) begin
                if_n++;
                if (if_n == if_drop) dif.if_req = 1'b0;
            end
            if (dif.ls_ack) begin
                ls_n++;
                if (ls_n == ls_drop) dif.ls_req = 1'b0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int cycles);
        rst        = 1'b1;
        dif.if_req = 1'b0;
        dif.ls_req = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst      = 1'b0;
        if_model = '0;
        ls_model = '0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0]       g_en, g_ack, g_ifack, g_busy;
        logic [DATA_W-1:0] r3;

        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        dif.if_req = 1'b0; dif.if_addr = '0;
        dif.ls_req = 1'b0; dif.ls_we = 1'b0; dif.ls_addr = '0; dif.ls_wdata = '0;
        dif3.if_req = 1'b0; dif3.if_addr = '0;
        dif3.ls_req = 1'b0; dif3.ls_we = 1'b0; dif3.ls_addr = '0; dif3.ls_wdata = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 64'({busy, sram_en, sram_we, dif.if_ack, dif.ls_ack}), 64'd0);
        check("reset_addr", 64'(sram_addr), 64'd0);
        check("reset_wdata", 64'(sram_wdata), 64'd0);
        check("reset_rdata", 64'({dif.if_rdata, dif.ls_rdata}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // IF read of 0x0010, READ_LAT=1
        if_issue(16'h0010);
        sample(6, 1, 1);
        check("if_rd_en", 64'(h_en), 64'h0002);
        check("if_rd_ack", 64'(h_ifack), 64'h0008);
        check("if_rd_no_ls_ack", 64'(h_lsack), 64'h0000);
        check("if_rd_busy", 64'(h_busy), 64'h0006);
        check("if_rd_addr", 64'(seen_addr), 64'h0010);
        check("if_rd_data", 64'(dif.if_rdata), 64'hDEAD_BEEF);
        check("if_rd_ls_rdata", 64'(dif.ls_rdata), 64'h0);

        // LS write of 0x12345678 to 0x0020
        ls_issue(1'b1, 16'h0020, 32'h1234_5678);
        sample(5, 1, 1);
        check("ls_wr_en", 64'(h_en), 64'h0002);
        check("ls_wr_we", 64'(h_we), 64'h0002);
        check("ls_wr_ack", 64'(h_lsack), 64'h0004);
        check("ls_wr_no_if_ack", 64'(h_ifack), 64'h0000);
        check("ls_wr_addr", 64'(seen_addr), 64'h0020);
        check("ls_wr_wdata", 64'(seen_wdata), 64'h1234_5678);
        check("ls_wr_addr_held", 64'(sram_addr), 64'h0020);

        // IF holds req across its ack: the ack cycle is masked, re-grant one cycle later
        if_issue(16'h0005);
        if_issue(16'h0005);
        sample(10, 2, 1);
        check("hold_en", 64'(h_en), 64'h0022);
        check("hold_ack", 64'(h_ifack), 64'h0088);
        check("hold_busy", 64'(h_busy), 64'h0066);

        // Tie from reset: grants alternate IF, LS, IF, LS
        do_reset(2);
        if_issue(16'h0003);
        if_issue(16'h0003);
        ls_issue(1'b0, 16'h0021, '0);
        ls_issue(1'b0, 16'h0021, '0);
        sample(15, 2, 2);
        check("tie_en", 64'(h_en), 64'h0492);
        check("tie_if_ack", 64'(h_ifack), 64'h0208);
        check("tie_ls_ack", 64'(h_lsack), 64'h1040);

        // Reset while a read sits in WAIT: no ack, everything back to zero
        if_issue(16'h0008);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_rd_busy", 64'(busy), 64'd1);
        rst        = 1'b1;
        dif.if_req = 1'b0;
        if_q.delete();
        if_model = '0;
        ls_model = '0;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_ctrl", 64'({busy, sram_en, sram_we, dif.if_ack, dif.ls_ack}), 64'd0);
            check("rst_regs", 64'({sram_addr, dif.if_rdata}), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_idle", 64'({busy, dif.if_ack, dif.ls_ack}), 64'd0);
        end
        @(posedge clk); #1;

        // READ_LAT=3 instance: LS read
        dif3.ls_we   = 1'b0;
        dif3.ls_addr = 16'h0007;
        dif3.ls_req  = 1'b1;
        g_en = '0; g_ack = '0; g_ifack = '0; g_busy = '0; r3 = '0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            g_en[k]    = s3_en;
            g_ack[k]   = dif3.ls_ack;
            g_ifack[k] = dif3.if_ack;
            g_busy[k]  = busy3;
            if (dif3.ls_ack) begin
                r3          = dif3.ls_rdata;
                dif3.ls_req = 1'b0;
            end
        end
        check("lat3_en", 64'(g_en), 64'h0002);
        check("lat3_ack", 64'(g_ack), 64'h0020);
        check("lat3_busy", 64'(g_busy), 64'h001E);
        check("lat3_no_if_ack", 64'(g_ifack), 64'h0000);
        check("lat3_rdata", 64'(r3), 64'hCAFE_0007);
        @(posedge clk); #1;

        // Randomized concurrent traffic on both ports
        fork
            if_random(150);
            ls_random(150);
        join
        repeat (10) @(posedge clk);
        #1;
        check("if_q_drained", 64'(if_q.size()), 64'd0);
        check("ls_q_drained", 64'(ls_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
